uart_frame_rx: RTL and testbench

- Receiving end of the 16-byte UART measurement frame link: deserialises RXD, assembles NUM_BYTES-byte frames and unpacks the four 10-bit channel values.
- Sits on the visualisation/host-side board and feeds the display path with ver_data/ver_valid.
- Frame boundaries come from a line-idle timeout, since the transmitter leaves a long idle gap between frames.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_byte_rx.sv | 133 +++++++++++++
 rtl/uart_frame_rx.sv | 114 +++++++++++
 tb/tb_uart_frame_rx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Constants and types shared by both ends of the measurement frame link.
// The channel field offsets are used by the transmitter and the receiver, so both pack frames the same way.
package uart_pkg;

    localparam int DEF_CLKS_PER_BIT = 434;
    localparam int FRAME_BYTES      = 16;
    localparam int CH_W             = 10;
    localparam int NUM_CH           = 4;
    localparam int DEC_BYTES        = 8;

    // Bit offset of each channel in the little-endian frame (byte k holds bits 8k+7..8k)
    localparam int CH0_OFF = 6;
    localparam int CH1_OFF = 22;
    localparam int CH2_OFF = 38;
    localparam int CH3_OFF = 54;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: RXD synchroniser, bit-timing counter and byte FSM.
// byte_done/byte_err are single-cycle strobes raised in the stop-bit sample cycle.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_byte,
    output logic       byte_done,
    output logic       byte_err,
    output logic       line_idle
);

    localparam int               CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             sync1_r;
    logic             rxs_r;
    rx_state_e        state_r;
    rx_state_e        state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [2:0]       bit_r;
    logic [2:0]       bit_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_s;
    logic             armed_r;
    logic             armed_s;
    logic             done_s;
    logic             err_s;

    // Two-flop synchroniser for the asynchronous line; resets to the idle level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= rxd;
            rxs_r   <= sync1_r;
        end
    end

    // Byte FSM state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            bit_r   <= 3'd0;
            shift_r <= 8'h00;
            armed_r <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            armed_r <= armed_s;
        end
    end

    // Next-state logic; armed_r makes IDLE see a high line before accepting a start edge
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        armed_s = armed_r;
        done_s  = 1'b0;
        err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_s = '0;
                bit_s = 3'd0;
                if (rxs_r) begin
                    armed_s = 1'b1;
                end else if (armed_r) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == HALF_M1) begin
                    cnt_s   = '0;
                    state_s = rxs_r ? IDLE : DATA;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_r == FULL_M1) begin
                    cnt_s   = '0;
                    shift_s = {rxs_r, shift_r[7:1]};
                    if (bit_r == 3'd7) begin
                        state_s = STOP;
                    end else begin
                        bit_s = bit_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_r == FULL_M1) begin
                    cnt_s   = '0;
                    state_s = IDLE;
                    if (rxs_r) begin
                        done_s = 1'b1;
                    end else begin
                        err_s   = 1'b1;
                        armed_s = 1'b0;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
                armed_s = 1'b0;
            end
        endcase
    end

    assign rx_byte   = shift_r;
    assign byte_done = done_s;
    assign byte_err  = err_s;
    assign line_idle = (state_r == IDLE) && rxs_r;

endmodule

// File: rtl/uart_frame_rx.sv
// Frame receiver: collects NUM_BYTES bytes, delimits frames by line-idle timeout
// and unpacks the four 10-bit channel values from the first eight bytes.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int NUM_BYTES    = FRAME_BYTES,
    parameter int IDLE_BITS    = 20
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           RXD,
    output logic [NUM_CH*CH_W-1:0]         ver_data,
    output logic                           ver_valid,
    output logic                           frame_err,
    output logic [$clog2(NUM_BYTES+1)-1:0] byte_idx
);

    localparam int               IDX_W      = $clog2(NUM_BYTES + 1);
    localparam int               BUF_AW     = $clog2(DEC_BYTES);
    localparam int               IDLE_LIMIT = IDLE_BITS * CLKS_PER_BIT;
    localparam int               IC_W       = $clog2(IDLE_LIMIT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BYTES);
    localparam logic [IDX_W-1:0] DEC_IDX    = IDX_W'(DEC_BYTES);
    localparam logic [IC_W-1:0]  IDLE_MAX   = IC_W'(IDLE_LIMIT);
    localparam logic [IC_W-1:0]  IDLE_HIT   = IC_W'(IDLE_LIMIT - 1);

    logic [7:0]             rx_byte_s;
    logic                   byte_done_s;
    logic                   byte_err_s;
    logic                   line_idle_s;
    logic [IC_W-1:0]        idle_cnt_r;
    logic                   timeout_s;
    logic [7:0]             buf_r [DEC_BYTES];
    logic [DEC_BYTES*8-1:0] dec_s;
    logic [NUM_CH*CH_W-1:0] unpack_s;
    logic                   unused_fill_s;

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rxd       (RXD),
        .rx_byte   (rx_byte_s),
        .byte_done (byte_done_s),
        .byte_err  (byte_err_s),
        .line_idle (line_idle_s)
    );

    // Flatten the decoded bytes into frame bit order
    always_comb begin
        dec_s = '0;
        for (int i = 0; i < DEC_BYTES; i++) begin
            dec_s[i*8 +: 8] = buf_r[i];
        end
    end

    assign unpack_s = {dec_s[CH3_OFF +: CH_W], dec_s[CH2_OFF +: CH_W],
                       dec_s[CH1_OFF +: CH_W], dec_s[CH0_OFF +: CH_W]};

    // The low six bits of each even byte carry no channel data
    assign unused_fill_s = ^{dec_s[CH0_OFF-1:0], dec_s[CH1_OFF-1:CH0_OFF+CH_W],
                             dec_s[CH2_OFF-1:CH1_OFF+CH_W], dec_s[CH3_OFF-1:CH2_OFF+CH_W]};

    assign timeout_s = line_idle_s && (idle_cnt_r == IDLE_HIT);

    // Saturating idle-line counter, cleared whenever the byte FSM leaves idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_r <= '0;
        end else if (!line_idle_s) begin
            idle_cnt_r <= '0;
        end else if (idle_cnt_r != IDLE_MAX) begin
            idle_cnt_r <= idle_cnt_r + IC_W'(1);
        end else begin
            idle_cnt_r <= idle_cnt_r;
        end
    end

    // Frame assembly; the full-frame check sits first so a completed frame is
    // published the cycle after its last byte, and byte_done outranks the timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ver_data  <= '0;
            ver_valid <= 1'b0;
            frame_err <= 1'b0;
            byte_idx  <= '0;
            for (int i = 0; i < DEC_BYTES; i++) begin
                buf_r[i] <= 8'h00;
            end
        end else begin
            ver_valid <= 1'b0;
            frame_err <= 1'b0;
            if (byte_idx == LAST_IDX) begin
                ver_valid <= 1'b1;
                ver_data  <= unpack_s;
                byte_idx  <= '0;
            end else if (byte_done_s) begin
                if (byte_idx < DEC_IDX) begin
                    buf_r[byte_idx[BUF_AW-1:0]] <= rx_byte_s;
                end
                byte_idx <= byte_idx + IDX_W'(1);
            end else if (byte_err_s) begin
                frame_err <= 1'b1;
                byte_idx  <= '0;
            end else if (timeout_s && (byte_idx != '0)) begin
                frame_err <= 1'b1;
                byte_idx  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Self-checking bench for uart_frame_rx: serial frames are driven on RXD and
// the expected channel words are queued and compared as ver_valid pulses arrive.
module tb_uart_frame_rx;

    localparam int CPB = 8;
    localparam int NB  = 16;
    localparam int IB  = 20;
    // ver_valid is seen CPB negedges after the last stop bit starts; frame_err one earlier
    localparam int VV_LAT = CPB;
    localparam int FE_LAT = CPB - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxd = 1'b1;
    logic [39:0] ver_data;
    logic        ver_valid;
    logic        frame_err;
    logic [4:0]  byte_idx;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          vv_cnt = 0;
    int          fe_cnt = 0;
    int          fe_cyc = -1;
    int          last_stop_cyc = 0;
    logic        vv_prev = 1'b0;
    logic [39:0] exp_q[$];
    logic [39:0] mon_exp;
    logic [7:0]  fb [NB];

    uart_frame_rx #(
        .CLKS_PER_BIT(CPB),
        .NUM_BYTES   (NB),
        .IDLE_BITS   (IB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RXD       (rxd),
        .ver_data  (ver_data),
        .ver_valid (ver_valid),
        .frame_err (frame_err),
        .byte_idx  (byte_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every ver_valid pulse must match the oldest queued frame
    always @(negedge clk) begin
        if (ver_valid) begin
            vv_cnt++;
            n_chk++;
            if (vv_prev) begin
                n_fail++;
                $display("FAIL valid_width: ver_valid high on consecutive cycles at cyc %0d", cyc);
            end
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid: ver_data=%h, no frame expected", ver_data);
            end else begin
                mon_exp = exp_q.pop_front();
                n_chk++;
                if (ver_data !== mon_exp) begin
                    n_fail++;
                    $display("FAIL frame_data: got %h expected %h", ver_data, mon_exp);
                end
                n_chk++;
                if (cyc !== last_stop_cyc + VV_LAT) begin
                    n_fail++;
                    $display("FAIL valid_latency: got cyc %0d expected %0d", cyc, last_stop_cyc + VV_LAT);
                end
            end
        end
        if (frame_err) begin
            fe_cnt++;
            fe_cyc = cyc;
        end
        vv_prev = ver_valid;
    end

    task automatic send_bit(input logic v);
        rxd = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        last_stop_cyc = cyc;
        send_bit(stop_v);
    endtask

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    // Channel k: low two bits in byte 2k[7:6], high eight bits in byte 2k+1
    task automatic build_frame(input logic [9:0] v0, input logic [9:0] v1,
                               input logic [9:0] v2, input logic [9:0] v3,
                               input bit rand_fill);
        logic [9:0] v [4];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        for (int k = 0; k < 4; k++) begin
            fb[2*k]     = {v[k][1:0], (rand_fill ? 6'($urandom) : 6'd0)};
            fb[2*k + 1] = v[k][9:2];
        end
        for (int k = 8; k < NB; k++) fb[k] = rand_fill ? 8'($urandom) : 8'h00;
    endtask

    task automatic send_frame(input logic [9:0] v0, input logic [9:0] v1,
                              input logic [9:0] v2, input logic [9:0] v3,
                              input bit rand_fill);
        build_frame(v0, v1, v2, v3, rand_fill);
        exp_q.push_back({v3, v2, v1, v0});
        for (int k = 0; k < NB; k++) send_byte(fb[k], 1'b1);
    endtask

    task automatic check_frame_done(input string name, input int vv0, input int nvv,
                                    input logic [39:0] expd);
        n_chk++;
        if (vv_cnt - vv0 !== nvv) begin
            n_fail++;
            $display("FAIL %s_valid_count: got %0d expected %0d", name, vv_cnt - vv0, nvv);
        end
        n_chk++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL %s_pending: %0d expected frames never seen", name, exp_q.size());
            exp_q.delete();
        end
        n_chk++;
        if (ver_data !== expd) begin
            n_fail++;
            $display("FAIL %s_data_held: got %h expected %h", name, ver_data, expd);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk += 4;
        if (ver_data !== 40'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", ver_data); end
        if (ver_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", ver_valid); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", frame_err); end
        if (byte_idx !== 5'd0) begin n_fail++; $display("FAIL reset_idx: got %0d expected 0", byte_idx); end
        rst_n = 1'b1;
        idle_bits(2);
    endtask

    task automatic test_good_frame();
        int vv0 = vv_cnt;
        int fe0 = fe_cnt;
        send_frame(10'h155, 10'h100, 10'h300, 10'h3FF, 1'b0);
        idle_bits(IB);
        check_frame_done("good", vv0, 1, 40'hFFF0040155);
        n_chk += 2;
        if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL good_err: got %0d pulses expected 0", fe_cnt - fe0); end
        if (byte_idx !== 5'd0) begin n_fail++; $display("FAIL good_idx: got %0d expected 0", byte_idx); end
    endtask

    task automatic test_back_to_back();
        int vv0 = vv_cnt;
        send_frame(10'h001, 10'h2AA, 10'h0F0, 10'h201, 1'b1);
        idle_bits(IB);
        n_chk++;
        if (ver_data !== {10'h201, 10'h0F0, 10'h2AA, 10'h001}) begin
            n_fail++;
            $display("FAIL b2b_hold: got %h expected %h", ver_data, {10'h201, 10'h0F0, 10'h2AA, 10'h001});
        end
        send_frame(10'h002, 10'h155, 10'h3C3, 10'h07E, 1'b1);
        idle_bits(IB);
        check_frame_done("b2b", vv0, 2, {10'h07E, 10'h3C3, 10'h155, 10'h002});
    endtask

    task automatic test_stop_err();
        int vv0 = vv_cnt;
        int fe0 = fe_cnt;
        logic [39:0] held = ver_data;
        build_frame(10'h2F0, 10'h00F, 10'h1A5, 10'h333, 1'b1);
        for (int k = 0; k < 5; k++) send_byte(fb[k], 1'b1);
        n_chk++;
        if (byte_idx !== 5'd5) begin n_fail++; $display("FAIL stop_idx_before: got %0d expected 5", byte_idx); end
        send_byte(fb[5], 1'b0);
        rxd = 1'b1;
        @(negedge clk);
        n_chk += 4;
        if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL stop_err_count: got %0d expected 1", fe_cnt - fe0); end
        if (fe_cyc !== last_stop_cyc + FE_LAT) begin
            n_fail++;
            $display("FAIL stop_err_latency: got cyc %0d expected %0d", fe_cyc, last_stop_cyc + FE_LAT);
        end
        if (byte_idx !== 5'd0) begin n_fail++; $display("FAIL stop_idx_after: got %0d expected 0", byte_idx); end
        if (vv_cnt - vv0 !== 0) begin n_fail++; $display("FAIL stop_no_valid: got %0d pulses expected 0", vv_cnt - vv0); end
        check_frame_done("stop_held", vv0, 0, held);
        idle_bits(IB);
        send_frame(10'h3C3, 10'h0A5, 10'h200, 10'h010, 1'b1);
        idle_bits(IB);
        check_frame_done("stop_recover", vv0, 1, {10'h010, 10'h200, 10'h0A5, 10'h3C3});
    endtask

    task automatic test_glitch();
        int vv0 = vv_cnt;
        int fe0 = fe_cnt;
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        idle_bits(4);
        n_chk += 3;
        if (byte_idx !== 5'd0) begin n_fail++; $display("FAIL glitch_idx: got %0d expected 0", byte_idx); end
        if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL glitch_err: got %0d pulses expected 0", fe_cnt - fe0); end
        if (vv_cnt - vv0 !== 0) begin n_fail++; $display("FAIL glitch_valid: got %0d pulses expected 0", vv_cnt - vv0); end
    endtask

    task automatic test_timeout();
        int vv0 = vv_cnt;
        int fe0 = fe_cnt;
        build_frame(10'h111, 10'h222, 10'h333, 10'h044, 1'b1);
        for (int k = 0; k < 7; k++) send_byte(fb[k], 1'b1);
        n_chk++;
        if (byte_idx !== 5'd7) begin n_fail++; $display("FAIL timeout_idx_before: got %0d expected 7", byte_idx); end
        idle_bits(15);
        n_chk += 2;
        if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL timeout_early: got %0d pulses expected 0", fe_cnt - fe0); end
        if (byte_idx !== 5'd7) begin n_fail++; $display("FAIL timeout_idx_hold: got %0d expected 7", byte_idx); end
        idle_bits(10);
        n_chk += 3;
        if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL timeout_err_count: got %0d expected 1", fe_cnt - fe0); end
        if (byte_idx !== 5'd0) begin n_fail++; $display("FAIL timeout_idx_after: got %0d expected 0", byte_idx); end
        if (vv_cnt - vv0 !== 0) begin n_fail++; $display("FAIL timeout_valid: got %0d pulses expected 0", vv_cnt - vv0); end
        send_frame(10'h0C0, 10'h3FE, 10'h001, 10'h2D2, 1'b1);
        idle_bits(IB);
        check_frame_done("timeout_recover", vv0, 1, {10'h2D2, 10'h001, 10'h3FE, 10'h0C0});
    endtask

    task automatic test_reset_mid_frame();
        int vv0 = vv_cnt;
        build_frame(10'h1E1, 10'h2B4, 10'h077, 10'h3A0, 1'b1);
        for (int k = 0; k < 10; k++) send_byte(fb[k], 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(fb[10][i]);
        rxd = fb[10][3];
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_chk += 4;
        if (ver_data !== 40'h0) begin n_fail++; $display("FAIL midrst_data: got %h expected 0", ver_data); end
        if (ver_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", ver_valid); end
        if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b expected 0", frame_err); end
        if (byte_idx !== 5'd0) begin n_fail++; $display("FAIL midrst_idx: got %0d expected 0", byte_idx); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 4; i < 8; i++) send_bit(fb[10][i]);
        send_bit(1'b1);
        for (int k = 11; k < NB; k++) send_byte(fb[k], 1'b1);
        idle_bits(30);
        n_chk++;
        if (vv_cnt - vv0 !== 0) begin n_fail++; $display("FAIL midrst_no_valid: got %0d pulses expected 0", vv_cnt - vv0); end
        send_frame(10'h155, 10'h2AA, 10'h0FF, 10'h300, 1'b1);
        idle_bits(IB);
        check_frame_done("midrst_recover", vv0, 1, {10'h300, 10'h0FF, 10'h2AA, 10'h155});
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_stop_err();
        test_glitch();
        test_timeout();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
